crypto_engine: RTL and testbench

Iterative symmetric cipher engine that responds to the control unit's crypto handshake. The control unit drives `Load_data` with `start_crypt` or `start_decrypt`, then `start_execute_crypto`, then `Store_data`. This block latches operand and key, runs a fixed number of rounds (one per clock), raises `fin_crypto`, and holds the result for write-back to data memory. It sits between the data-memory read path and the data-memory write path.

---
 rtl/crypto_pkg.sv | 24 ++
 rtl/crypto_engine_if.sv | 42 ++++
 rtl/crypto_round.sv | 37 +++
 rtl/crypto_engine.sv | 134 +++++++++++++
 tb/tb_crypto_engine.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/crypto_pkg.sv
// -----------------------------------------------------------------------------
// crypto_pkg
// Shared types and defaults for the iterative cipher engine.
//   state_t      : engine control state (IDLE, LOADED, RUN, DONE)
//   ENC / DEC    : mode encoding, matching the control unit's register select
//   DEF_*        : default data width, round count and per-round rotate
// -----------------------------------------------------------------------------
package crypto_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic ENC = 1'b0;
   localparam logic DEC = 1'b1;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ROUNDS = 8;
   localparam int DEF_ROT    = 3;

endpackage

// File: rtl/crypto_engine_if.sv
// -----------------------------------------------------------------------------
// crypto_engine_if
// Crypto handshake between the control unit (master) and the engine (slave).
//   start_crypt / start_decrypt : mode select, qualified by Load_data
//   Load_data                   : latch data_in, key_in and mode
//   start_execute_crypto        : begin rounds
//   Store_data                  : result consumed, release engine
//   data_in / key_in            : operand and key
//   data_out                    : held result
//   fin_crypto                  : result valid until released or reloaded
//   busy                        : rounds in progress
// -----------------------------------------------------------------------------
interface crypto_engine_if
   import crypto_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              start_crypt;
   logic              start_decrypt;
   logic              Load_data;
   logic              start_execute_crypto;
   logic              Store_data;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] key_in;
   logic [DATA_W-1:0] data_out;
   logic              fin_crypto;
   logic              busy;

   modport master (
      output start_crypt, start_decrypt, Load_data, start_execute_crypto,
             Store_data, data_in, key_in,
      input  data_out, fin_crypto, busy
   );

   modport slave (
      input  start_crypt, start_decrypt, Load_data, start_execute_crypto,
             Store_data, data_in, key_in,
      output data_out, fin_crypto, busy
   );

endinterface

// File: rtl/crypto_round.sv
// -----------------------------------------------------------------------------
// crypto_round
// One combinational cipher round.
//   x    : round input
//   k    : round key
//   mode : ENC or DEC
//   y    : round output
// Encrypt: y = rotl(x ^ k, ROT) + k
// Decrypt: y = rotr(x - k, ROT) ^ k   (exact inverse of encrypt)
// -----------------------------------------------------------------------------
module crypto_round
   import crypto_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ROT    = DEF_ROT
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] k,
   input  logic              mode,
   output logic [DATA_W-1:0] y
);

   logic [DATA_W-1:0] mix_enc;
   logic [DATA_W-1:0] mix_dec;
   logic [DATA_W-1:0] out_enc;
   logic [DATA_W-1:0] out_dec;

   assign mix_enc = x ^ k;
   assign mix_dec = x - k;

   // Rotates are fixed-amount, so they reduce to plain wiring.
   assign out_enc = {mix_enc[DATA_W-ROT-1:0], mix_enc[DATA_W-1:DATA_W-ROT]} + k;
   assign out_dec = {mix_dec[ROT-1:0], mix_dec[DATA_W-1:ROT]} ^ k;

   assign y = (mode == ENC) ? out_enc : out_dec;

endmodule

// File: rtl/crypto_engine.sv
// -----------------------------------------------------------------------------
// crypto_engine
// Iterative symmetric cipher: latches operand/key/mode on Load_data, runs
// ROUNDS rounds (one per clock) after start_execute_crypto, then holds the
// result in data_out with fin_crypto high until Store_data or a new load.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : crypto_engine_if slave port (handshake, operand, key, result)
// -----------------------------------------------------------------------------
module crypto_engine
   import crypto_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ROUNDS = DEF_ROUNDS,
   parameter int ROT    = DEF_ROT
) (
   input  logic           clk,
   input  logic           rst,
   crypto_engine_if.slave bus
);

   localparam int               CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(ROUNDS - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              mode_q, mode_d;
   logic              fin_q, fin_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  idx;
   logic [DATA_W-1:0] round_key;
   logic [DATA_W-1:0] round_out;
   logic              load_ok;

   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] v,
                                              input int amt);
      if (amt == 0) return v;
      return (v << amt) | (v >> (DATA_W - amt));
   endfunction

   // Decrypt walks the key schedule backwards so it undoes encrypt in order.
   assign idx       = (mode_q == ENC) ? cnt_q : LAST - cnt_q;
   assign round_key = rotl(key_q, int'(idx) % DATA_W) ^ DATA_W'(idx);

   crypto_round #(
      .DATA_W (DATA_W),
      .ROT    (ROT)
   ) u_round (
      .x    (x_q),
      .k    (round_key),
      .mode (mode_q),
      .y    (round_out)
   );

   // A load needs exactly one mode bit and is refused while rounds run.
   assign load_ok = bus.Load_data && (bus.start_crypt != bus.start_decrypt)
                    && (state_q != RUN);

   always_comb begin
      // NOTE: every variable gets its hold value first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      x_d     = x_q;
      key_d   = key_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      fin_d   = fin_q;

      if (load_ok) begin
         // Load outranks a same-cycle execute or store.
         state_d = LOADED;
         x_d     = bus.data_in;
         key_d   = bus.key_in;
         mode_d  = bus.start_decrypt ? DEC : ENC;
         fin_d   = 1'b0;
      end else begin
         unique case (state_q)
            LOADED: begin
               if (bus.start_execute_crypto) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            end
            RUN: begin
               x_d   = round_out;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_d = DONE;
                  dout_d  = round_out;
                  fin_d   = 1'b1;
                  cnt_d   = '0;
               end
            end
            DONE: begin
               if (bus.Store_data) begin
                  state_d = IDLE;
                  fin_d   = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         key_q   <= '0;
         mode_q  <= ENC;
         cnt_q   <= '0;
         dout_q  <= '0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         key_q   <= key_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         fin_q   <= fin_d;
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.fin_crypto = fin_q;
   assign bus.busy       = (state_q == RUN);

endmodule

// File: tb/tb_crypto_engine.sv
// -----------------------------------------------------------------------------
// tb_crypto_engine
// Directed bench for crypto_engine. Three instances (ROUNDS = 1, 2, 8) share
// the same stimulus; each section resets them all and checks one instance.
// -----------------------------------------------------------------------------
module tb_crypto_engine;
   import crypto_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   crypto_engine_if #(.DATA_W(16)) if1 ();
   crypto_engine_if #(.DATA_W(16)) if2 ();
   crypto_engine_if #(.DATA_W(16)) if8 ();

   crypto_engine #(.ROUNDS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
   crypto_engine #(.ROUNDS(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
   crypto_engine #(.ROUNDS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

   // Reference cipher written directly from the algorithm description.
   function automatic logic [15:0] rotl16(input logic [15:0] v, input int a);
      logic [31:0] t;
      t = {v, v} << (a % 16);
      return t[31:16];
   endfunction

   function automatic logic [15:0] model_enc(input logic [15:0] d,
                                             input logic [15:0] k);
      logic [15:0] x, ki;
      x = d;
      for (int i = 0; i < 8; i++) begin
         ki = rotl16(k, i) ^ 16'(i);
         x  = rotl16(x ^ ki, 3) + ki;
      end
      return x;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic sc, input logic sd,
                        input logic ex, input logic st,
                        input logic [15:0] d, input logic [15:0] k);
      if1.Load_data = ld; if1.start_crypt = sc; if1.start_decrypt = sd;
      if1.start_execute_crypto = ex; if1.Store_data = st;
      if1.data_in = d; if1.key_in = k;
      if2.Load_data = ld; if2.start_crypt = sc; if2.start_decrypt = sd;
      if2.start_execute_crypto = ex; if2.Store_data = st;
      if2.data_in = d; if2.key_in = k;
      if8.Load_data = ld; if8.start_crypt = sc; if8.start_decrypt = sd;
      if8.start_execute_crypto = ex; if8.Store_data = st;
      if8.data_in = d; if8.key_in = k;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one set of inputs across a single rising edge, then idle them.
   task automatic pulse(input logic ld, input logic sc, input logic sd,
                        input logic ex, input logic st,
                        input logic [15:0] d, input logic [15:0] k);
      drive(ld, sc, sd, ex, st, d, k);
      tick();
      drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Count edges with busy high on the 8-round instance, bounded.
   task automatic wait_done8(output int n);
      n = 0;
      while (if8.busy === 1'b1 && n < 50) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      logic [15:0] key, data, ct;
      int          dly;

      drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_state", 32'(dut8.state_q), 32'(IDLE));
      check("rst_busy", 32'(if8.busy), 32'd0);
      check("rst_fin", 32'(if8.fin_crypto), 32'd0);
      check("rst_dout", 32'(if8.data_out), 32'h0);

      // ROUNDS=1 encrypt: key 0x0001, data 0x1234 -> 0x91A9
      pulse(1, 1, 0, 0, 0, 16'h1234, 16'h0001);
      check("r1_loaded", 32'(dut1.state_q), 32'(LOADED));
      pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
      check("r1_busy", 32'(if1.busy), 32'd1);
      check("r1_fin_early", 32'(if1.fin_crypto), 32'd0);
      tick();
      check("r1_fin", 32'(if1.fin_crypto), 32'd1);
      check("r1_dout", 32'(if1.data_out), 32'h91A9);
      check("r1_busy_off", 32'(if1.busy), 32'd0);

      // ROUNDS=2 encrypt zeros -> 0x0009, then decrypt back to 0x0000
      do_reset();
      pulse(1, 1, 0, 0, 0, 16'h0000, 16'h0000);
      pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
      tick();
      check("r2_busy", 32'(if2.busy), 32'd1);
      check("r2_fin_early", 32'(if2.fin_crypto), 32'd0);
      tick();
      check("r2_fin", 32'(if2.fin_crypto), 32'd1);
      check("r2_enc", 32'(if2.data_out), 32'h0009);
      pulse(1, 0, 1, 0, 0, 16'h0009, 16'h0000);
      check("r2_load_fin", 32'(if2.fin_crypto), 32'd0);
      check("r2_load_dout", 32'(if2.data_out), 32'h0009);
      pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
      tick();
      tick();
      check("r2_dec_fin", 32'(if2.fin_crypto), 32'd1);
      check("r2_dec", 32'(if2.data_out), 32'h0000);

      // Default params: random encrypt/decrypt round trips
      do_reset();
      for (int t = 0; t < 200; t++) begin
         key  = 16'($urandom);
         data = 16'($urandom);
         pulse(1, 1, 0, 0, 0, data, key);
         pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
         wait_done8(n);
         check("rnd_enc_busy_cycles", 32'(n), 32'd8);
         check("rnd_enc_fin", 32'(if8.fin_crypto), 32'd1);
         check("rnd_enc_val", 32'(if8.data_out), 32'(model_enc(data, key)));
         ct  = model_enc(data, key);
         dly = $urandom_range(0, 5);
         for (int j = 0; j < dly; j++) tick();
         check("rnd_enc_fin_hold", 32'(if8.fin_crypto), 32'd1);
         pulse(0, 0, 0, 0, 1, 16'h0, 16'h0);
         check("rnd_store_fin", 32'(if8.fin_crypto), 32'd0);
         check("rnd_store_dout", 32'(if8.data_out), 32'(ct));
         pulse(1, 0, 1, 0, 0, ct, key);
         pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
         wait_done8(n);
         check("rnd_dec_busy_cycles", 32'(n), 32'd8);
         check("rnd_dec_val", 32'(if8.data_out), 32'(data));
         dly = $urandom_range(0, 5);
         for (int j = 0; j < dly; j++) tick();
         check("rnd_dec_fin_hold", 32'(if8.fin_crypto), 32'd1);
         pulse(0, 0, 0, 0, 1, 16'h0, 16'h0);
         check("rnd_dec_release", 32'(dut8.state_q), 32'(IDLE));
      end

      // Protocol abuse on the 8-round instance
      do_reset();
      pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
      check("abuse_exec_idle_state", 32'(dut8.state_q), 32'(IDLE));
      check("abuse_exec_idle_busy", 32'(if8.busy), 32'd0);
      pulse(1, 1, 1, 0, 0, 16'hAAAA, 16'h5555);
      check("abuse_both_idle", 32'(dut8.state_q), 32'(IDLE));
      pulse(1, 1, 0, 0, 0, 16'hBEEF, 16'h1234);
      check("load_ok", 32'(dut8.state_q), 32'(LOADED));
      pulse(0, 0, 0, 0, 1, 16'h0, 16'h0);
      check("abuse_store_loaded", 32'(dut8.state_q), 32'(LOADED));
      check("abuse_store_loaded_fin", 32'(if8.fin_crypto), 32'd0);
      pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
      tick();
      pulse(1, 0, 1, 0, 0, 16'h1111, 16'h2222);
      check("abuse_load_run_busy", 32'(if8.busy), 32'd1);
      check("abuse_load_run_state", 32'(dut8.state_q), 32'(RUN));
      wait_done8(n);
      check("abuse_load_run_cycles", 32'(n), 32'd6);
      check("abuse_load_run_val", 32'(if8.data_out), 32'(model_enc(16'hBEEF, 16'h1234)));
      pulse(1, 1, 1, 0, 0, 16'hAAAA, 16'h5555);
      check("abuse_both_done_state", 32'(dut8.state_q), 32'(DONE));
      check("abuse_both_done_fin", 32'(if8.fin_crypto), 32'd1);

      // Load and Store together in DONE: load wins, result retained
      pulse(1, 1, 0, 0, 1, 16'h0BAD, 16'hF00D);
      check("ldst_state", 32'(dut8.state_q), 32'(LOADED));
      check("ldst_fin", 32'(if8.fin_crypto), 32'd0);
      check("ldst_dout", 32'(if8.data_out), 32'(model_enc(16'hBEEF, 16'h1234)));

      // Reset during RUN cycle 3 aborts everything
      pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
      tick();
      tick();
      check("rst_run_busy_before", 32'(if8.busy), 32'd1);
      do_reset();
      check("rst_run_state", 32'(dut8.state_q), 32'(IDLE));
      check("rst_run_busy", 32'(if8.busy), 32'd0);
      check("rst_run_fin", 32'(if8.fin_crypto), 32'd0);
      check("rst_run_dout", 32'(if8.data_out), 32'h0);
      pulse(1, 1, 0, 0, 0, 16'h1234, 16'h0F0F);
      pulse(0, 0, 0, 1, 0, 16'h0, 16'h0);
      wait_done8(n);
      check("rst_fresh_cycles", 32'(n), 32'd8);
      check("rst_fresh_fin", 32'(if8.fin_crypto), 32'd1);
      check("rst_fresh_val", 32'(if8.data_out), 32'(model_enc(16'h1234, 16'h0F0F)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
